buffer_arbiter: RTL and testbench

Shares one adder+FIFO buffer instance between NUM_REQ requesters, each presenting operand pairs over a valid/ready handshake. Round-robin arbitration selects one requester per cycle. The block tracks FIFO occupancy itself, and a read-side FSM drains FIFO sums to a single consumer over valid/ready. It sits directly in front of and behind the buffer and drives its in0/in1/in_en/out_en pins.

---
 rtl/buffer_arbiter_pkg.sv | 15 +
 rtl/buffer_arbiter_if.sv | 32 +++
 rtl/buffer_arbiter_rr_arbiter.sv | 39 +++
 rtl/buffer_arbiter.sv | 99 +++++++++
 tb/tb_buffer_arbiter.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/buffer_arbiter_pkg.sv
// Shared types and default sizes for the buffer arbiter and its round-robin sub-block.
package buffer_arbiter_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_WAIT = 2'd1,
        RD_HOLD = 2'd2
    } rd_state_e;

    localparam int DEF_N       = 32;
    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_CNT_W   = 5;

endpackage

// File: rtl/buffer_arbiter_if.sv
// Requester, buffer-pin and consumer signals of the buffer arbiter; master is the arbiter side.
interface buffer_arbiter_if #(
    parameter int N       = 32,
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 5
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*N-1:0] req_in0;
    logic [NUM_REQ*N-1:0] req_in1;
    logic [NUM_REQ-1:0]   req_ready;
    logic [N-1:0]         buf_in0;
    logic [N-1:0]         buf_in1;
    logic                 buf_in_en;
    logic                 buf_out_en;
    logic [N-1:0]         buf_out;
    logic [N-1:0]         out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_W-1:0]     occupancy;

    modport master (
        input  req_valid, req_in0, req_in1, buf_out, out_ready,
        output req_ready, buf_in0, buf_in1, buf_in_en, buf_out_en,
               out_data, out_valid, occupancy
    );

    modport slave (
        output req_valid, req_in0, req_in1, buf_out, out_ready,
        input  req_ready, buf_in0, buf_in1, buf_in_en, buf_out_en,
               out_data, out_valid, occupancy
    );
endinterface

// File: rtl/buffer_arbiter_rr_arbiter.sv
// Combinational round-robin search starting at ptr; yields one-hot grant, its index and the next pointer.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic [PTR_W-1:0]   next_ptr
);
    logic             found;
    logic [PTR_W-1:0] cand;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PTR_W'(s);
    endfunction

    // With no request pending the index falls back to ptr, so the operand mux stays defined.
    always_comb begin
        found     = 1'b0;
        cand      = '0;
        grant_idx = ptr;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = wrap_add(ptr, k);
            if (!found && req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
        grant = '0;
        if (en && found) grant[grant_idx] = 1'b1;
        next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
    end
endmodule

// File: rtl/buffer_arbiter.sv
// Round-robin front end and drain FSM around a shared adder+FIFO buffer; tracks FIFO occupancy locally.
module buffer_arbiter
    import buffer_arbiter_pkg::*;
#(
    parameter int N       = DEF_N,
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    buffer_arbiter_if.master bus
);
    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   ptr_q, ptr_d, grant_idx, next_ptr;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   occ_q, occ_d;
    rd_state_e          state_q, state_d;
    logic               buf_out_en_q, buf_out_en_d;
    logic               out_valid_q, out_valid_d;
    logic               space, wr, rd, has_data;

    assign space    = (occ_q < CNT_W'(DEPTH));
    assign has_data = (occ_q != '0);

    rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req       (bus.req_valid),
        .ptr       (ptr_q),
        .en        (space),
        .grant     (grant),
        .grant_idx (grant_idx),
        .next_ptr  (next_ptr)
    );

    // Full blocks writes even when a read is leaving this cycle.
    always_comb begin
        wr    = (|bus.req_valid) && space;
        rd    = buf_out_en_q;
        ptr_d = wr ? next_ptr : ptr_q;
        occ_d = occ_q;
        if (wr && !rd)      occ_d = occ_q + CNT_W'(1);
        else if (!wr && rd) occ_d = occ_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RD_IDLE;
            ptr_q        <= '0;
            occ_q        <= '0;
            buf_out_en_q <= 1'b0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            occ_q        <= occ_d;
            buf_out_en_q <= buf_out_en_d;
            out_valid_q  <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RD_IDLE: if (has_data) state_d = RD_WAIT;
            RD_WAIT: state_d = RD_HOLD;
            RD_HOLD: if (bus.out_ready) state_d = has_data ? RD_WAIT : RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        buf_out_en_d = 1'b0;
        out_valid_d  = out_valid_q;
        case (state_q)
            RD_IDLE: begin
                out_valid_d  = 1'b0;
                buf_out_en_d = has_data;
            end
            RD_WAIT: out_valid_d = 1'b1;
            RD_HOLD: if (bus.out_ready) begin
                out_valid_d  = 1'b0;
                buf_out_en_d = has_data;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    assign bus.req_ready  = grant;
    assign bus.buf_in_en  = wr;
    assign bus.buf_in0    = bus.req_in0[grant_idx*N +: N];
    assign bus.buf_in1    = bus.req_in1[grant_idx*N +: N];
    assign bus.buf_out_en = buf_out_en_q;
    assign bus.occupancy  = occ_q;
    assign bus.out_valid  = out_valid_q;
    // The buffer output register only moves after buf_out_en, which never fires while a word is held,
    // so it is the held word for the whole of RD_HOLD.
    assign bus.out_data   = out_valid_q ? bus.buf_out : '0;
endmodule

// File: tb/tb_buffer_arbiter.sv
// Directed bench for buffer_arbiter with a behavioural adder+FIFO buffer on its buffer pins.
module tb_buffer_arbiter;
    import buffer_arbiter_pkg::*;

    localparam int N = 32, NR = 4, DEPTH = 16, CW = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [N-1:0] exp_q[$];

    always #5 clk = ~clk;

    buffer_arbiter_if #(.N(N), .NUM_REQ(NR), .CNT_W(CW)) bus ();

    buffer_arbiter #(.N(N), .NUM_REQ(NR), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Buffer model: sum pushed on in_en, popped into a registered output on out_en.
    logic [N-1:0] mem [DEPTH];
    logic [3:0]   wp, rp;
    logic [N-1:0] bout;
    always_ff @(posedge clk) begin
        if (rst) begin
            wp <= '0; rp <= '0; bout <= '0;
        end else begin
            if (bus.buf_in_en) begin
                mem[wp] <= bus.buf_in0 + bus.buf_in1;
                wp <= wp + 4'd1;
            end
            if (bus.buf_out_en) begin
                bout <= mem[rp];
                rp <= rp + 4'd1;
            end
        end
    end
    assign bus.buf_out = bout;

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_ops(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_in0[i*N +: N] = a;
        bus.req_in1[i*N +: N] = b;
    endtask

    task automatic test_reset();
        bus.req_valid = '0; bus.req_in0 = '0; bus.req_in1 = '0; bus.out_ready = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0; #1;
        checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL rst_req_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.buf_in_en !== 1'b0) begin failures++; $display("FAIL rst_buf_in_en got=%b exp=0", bus.buf_in_en); end
        checks++; if (bus.buf_out_en !== 1'b0) begin failures++; $display("FAIL rst_buf_out_en got=%b exp=0", bus.buf_out_en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL rst_out_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.occupancy !== 5'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", bus.occupancy); end
        checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL rst_ptr got=%0d exp=0", dut.ptr_q); end
        checks++; if (dut.state_q !== RD_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dut.state_q); end
    endtask

    task automatic test_single_write(input string tag);
        bus.out_ready = 1'b1;
        set_ops(2, 32'd5, 32'd7);
        bus.req_valid = 4'b0100; #1;
        checks++; if (bus.req_ready !== 4'b0100) begin failures++; $display("FAIL %s_req_ready got=%b exp=0100", tag, bus.req_ready); end
        checks++; if (bus.buf_in_en !== 1'b1) begin failures++; $display("FAIL %s_buf_in_en got=%b exp=1", tag, bus.buf_in_en); end
        tick(); bus.req_valid = '0; #1;
        checks++; if (dut.ptr_q !== 2'd3) begin failures++; $display("FAIL %s_ptr got=%0d exp=3", tag, dut.ptr_q); end
        checks++; if (bus.buf_out_en !== 1'b0) begin failures++; $display("FAIL %s_out_en_t1 got=%b exp=0", tag, bus.buf_out_en); end
        tick(); #1;
        checks++; if (bus.buf_out_en !== 1'b1) begin failures++; $display("FAIL %s_out_en_t2 got=%b exp=1", tag, bus.buf_out_en); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s_valid_t2 got=%b exp=0", tag, bus.out_valid); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid_t3 got=%b exp=1", tag, bus.out_valid); end
        checks++; if (bus.out_data !== 32'd12) begin failures++; $display("FAIL %s_data_t3 got=%0d exp=12", tag, bus.out_data); end
        tick(); #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL %s_valid_t4 got=%b exp=0", tag, bus.out_valid); end
        checks++; if (bus.occupancy !== 5'd0) begin failures++; $display("FAIL %s_occ_t4 got=%0d exp=0", tag, bus.occupancy); end
    endtask

    // Prime one held word (consumer stalled), then a 4-way burst of 8 grants.
    task automatic test_rr_burst();
        logic [3:0] exp_rdy;
        bus.out_ready = 1'b0;
        set_ops(3, 32'h55, 32'h1);
        bus.req_valid = 4'b1000;
        exp_q.push_back(32'h56);
        tick(); bus.req_valid = '0;
        for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL burst_prime_valid got=%b exp=1", bus.out_valid); end
        for (int i = 0; i < NR; i++) set_ops(i, 32'h100 * (i + 1), i);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            exp_rdy = 4'b0001 << (k % 4);
            checks++; if (bus.req_ready !== exp_rdy) begin failures++; $display("FAIL burst_grant%0d got=%b exp=%b", k, bus.req_ready, exp_rdy); end
            exp_q.push_back(32'h100 * ((k % 4) + 1) + (k % 4));
            tick();
        end
        bus.req_valid = '0; #1;
        checks++; if (bus.occupancy !== 5'd8) begin failures++; $display("FAIL burst_occ got=%0d exp=8", bus.occupancy); end
    endtask

    task automatic test_fill_and_drain();
        int guard;
        logic [N-1:0] e;
        bus.req_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            set_ops(0, 32'h200 + k, k); #1;
            checks++; if (bus.req_ready !== 4'b0001) begin failures++; $display("FAIL fill_ready%0d got=%b exp=0001", k, bus.req_ready); end
            exp_q.push_back(32'h200 + 2 * k);
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.occupancy !== 5'd16) begin failures++; $display("FAIL full_occ%0d got=%0d exp=16", k, bus.occupancy); end
            checks++; if (bus.req_ready !== 4'b0) begin failures++; $display("FAIL full_ready%0d got=%b exp=0000", k, bus.req_ready); end
            checks++; if (bus.buf_in_en !== 1'b0) begin failures++; $display("FAIL full_in_en%0d got=%b exp=0", k, bus.buf_in_en); end
            tick();
        end
        bus.req_valid = '0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 200) begin
            #1;
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                checks++; if (bus.out_data !== e) begin failures++; $display("FAIL drain_data got=%0h exp=%0h", bus.out_data, e); end
            end
            tick(); guard++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_timeout left=%0d exp=0", exp_q.size()); end
        tick(); tick(); #1;
        checks++; if (bus.occupancy !== 5'd0) begin failures++; $display("FAIL drain_occ got=%0d exp=0", bus.occupancy); end
        exp_q.delete();
    endtask

    task automatic test_same_cycle();
        int guard;
        logic [N-1:0] e;
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            set_ops(1, 32'h300 + k, 32'h10); exp_q.push_back(32'h310 + k);
            tick();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
        #1;
        checks++; if (bus.occupancy !== 5'd3) begin failures++; $display("FAIL same_pre_occ got=%0d exp=3", bus.occupancy); end
        bus.out_ready = 1'b1; #1;
        e = exp_q.pop_front();
        checks++; if (bus.out_data !== e) begin failures++; $display("FAIL same_held got=%0h exp=%0h", bus.out_data, e); end
        tick();
        bus.out_ready = 1'b0;
        set_ops(1, 32'h400, 32'h1); bus.req_valid = 4'b0010; exp_q.push_back(32'h401); #1;
        checks++; if ({bus.buf_out_en, bus.buf_in_en} !== 2'b11) begin failures++; $display("FAIL same_both_en got=%b exp=11", {bus.buf_out_en, bus.buf_in_en}); end
        tick(); bus.req_valid = '0; #1;
        checks++; if (bus.occupancy !== 5'd3) begin failures++; $display("FAIL same_occ got=%0d exp=3", bus.occupancy); end
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 50) begin
            #1;
            if (bus.out_valid) begin
                e = exp_q.pop_front();
                checks++; if (bus.out_data !== e) begin failures++; $display("FAIL same_drain got=%0h exp=%0h", bus.out_data, e); end
            end
            tick(); guard++;
        end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL same_timeout left=%0d exp=0", exp_q.size()); end
        exp_q.delete();
        tick(); tick();
    endtask

    task automatic test_carry();
        bus.out_ready = 1'b1;
        set_ops(0, 32'hFFFF_FFFF, 32'h2);
        bus.req_valid = 4'b0001;
        tick(); bus.req_valid = '0;
        tick(); tick(); #1;
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL carry_valid got=%b exp=1", bus.out_valid); end
        checks++; if (bus.out_data !== 32'h1) begin failures++; $display("FAIL carry_data got=%0h exp=1", bus.out_data); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        bus.req_valid = 4'b0100;
        for (int k = 0; k < 6; k++) begin
            set_ops(2, 32'h500 + k, 32'h0);
            tick();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 10 && !bus.out_valid; k++) tick();
        #1;
        checks++; if (dut.state_q !== RD_HOLD) begin failures++; $display("FAIL mid_state got=%0d exp=2", dut.state_q); end
        checks++; if (bus.occupancy !== 5'd5) begin failures++; $display("FAIL mid_occ got=%0d exp=5", bus.occupancy); end
        rst = 1'b1;
        tick(); rst = 1'b0; #1;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.occupancy !== 5'd0) begin failures++; $display("FAIL mid_rst_occ got=%0d exp=0", bus.occupancy); end
        checks++; if (bus.buf_out_en !== 1'b0) begin failures++; $display("FAIL mid_rst_out_en got=%b exp=0", bus.buf_out_en); end
        checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL mid_rst_ptr got=%0d exp=0", dut.ptr_q); end
        checks++; if (bus.out_data !== 32'h0) begin failures++; $display("FAIL mid_rst_data got=%0h exp=0", bus.out_data); end
        tick();
        test_single_write("post_rst");
    endtask

    initial begin
        test_reset();
        test_single_write("single");
        test_rr_burst();
        test_fill_and_drain();
        test_same_cycle();
        test_carry();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
